// File: rtl/fighter_anim_ctrl.sv
// Per-fighter action state machine feeding the sprite ROM address generator.
// Optional post-hit invulnerability window is enabled by defining MK_HIT_INVULN_EN.
module fighter_anim_ctrl #(
  parameter int RUN_STEP_FRAMES = 4,
  parameter int JUMP_FRAMES     = 24,
  parameter int KICK_FRAMES     = 12,
  parameter int PUNCH_FRAMES    = 8,
  parameter int HIT_FRAMES      = 10,
  parameter int INVULN_FRAMES   = 16
) (
  input  logic       CLK,
  input  logic       Reset_h,
  input  logic       frame_tick,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_kick,
  input  logic       key_punch,
  input  logic       hit_in,
  input  logic       health_zero,
  output logic       in_air,
  output logic       move_right,
  output logic       move_left,
  output logic       crouch,
  output logic       kick,
  output logic       punch,
  output logic       dir,
  output logic       p_hit,
  output logic       p_lose,
  output logic [2:0] run_state,
  output logic [4:0] count,
  output logic [9:0] boxsizex
);

  if (RUN_STEP_FRAMES < 1 || RUN_STEP_FRAMES > 31 ||
      JUMP_FRAMES < 1 || JUMP_FRAMES > 31 ||
      KICK_FRAMES < 1 || KICK_FRAMES > 31 ||
      PUNCH_FRAMES < 1 || PUNCH_FRAMES > 31 ||
      HIT_FRAMES < 1 || HIT_FRAMES > 31 ||
      INVULN_FRAMES < 0 || INVULN_FRAMES > 31) begin : g_param_check
    $error("fighter_anim_ctrl: frame parameters must lie in 1..31");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_CROUCH, S_JUMP, S_KICK, S_PUNCH, S_HIT, S_LOSE
  } state_t;

  localparam logic [4:0] RUN_LAST   = 5'(RUN_STEP_FRAMES - 1);
  localparam logic [4:0] JUMP_LAST  = 5'(JUMP_FRAMES - 1);
  localparam logic [4:0] KICK_LAST  = 5'(KICK_FRAMES - 1);
  localparam logic [4:0] PUNCH_LAST = 5'(PUNCH_FRAMES - 1);
  localparam logic [4:0] HIT_LAST   = 5'(HIT_FRAMES - 1);
  localparam logic [9:0] BOX_NARROW = 10'd64;
  localparam logic [9:0] BOX_WIDE   = 10'd104;

  state_t     state_reg, state_next;
  logic [4:0] phase_reg, phase_next;
  logic [2:0] run_next;
  logic [4:0] last_count;
  logic       enter, go_right, go_left, hit_ok;

  // Left and right together cancel out.
  assign go_right = key_right & ~key_left;
  assign go_left  = key_left & ~key_right;

`ifdef MK_HIT_INVULN_EN
  localparam logic [4:0] INV_LOAD = 5'(INVULN_FRAMES);
  logic [4:0] inv_reg;
  assign hit_ok = hit_in && (inv_reg == 5'd0);

  always_ff @(posedge CLK or posedge Reset_h) begin
    if (Reset_h) begin
      inv_reg <= 5'd0;
    end else if (frame_tick) begin
      if (state_reg == S_HIT && state_next == S_IDLE) begin
        inv_reg <= INV_LOAD;
      end else if (inv_reg != 5'd0) begin
        inv_reg <= inv_reg - 5'd1;
      end
    end
  end
`else
  assign hit_ok = hit_in;
`endif

  always_comb begin
    last_count = 5'd31;
    case (state_reg)
      S_JUMP:  last_count = JUMP_LAST;
      S_KICK:  last_count = KICK_LAST;
      S_PUNCH: last_count = PUNCH_LAST;
      S_HIT:   last_count = HIT_LAST;
      default: last_count = 5'd31;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    enter      = 1'b0;
    if (health_zero) begin
      state_next = S_LOSE;
    end else if (state_reg != S_LOSE && hit_ok) begin
      // A fresh hit while already stunned restarts the stun.
      state_next = S_HIT;
      enter      = 1'b1;
    end else begin
      case (state_reg)
        S_IDLE, S_RUN, S_CROUCH: begin
          if (key_up)                   state_next = S_JUMP;
          else if (key_down)            state_next = S_CROUCH;
          else if (key_kick)            state_next = S_KICK;
          else if (key_punch)           state_next = S_PUNCH;
          else if (go_right || go_left) state_next = S_RUN;
          else                          state_next = S_IDLE;
        end
        S_JUMP, S_KICK, S_PUNCH, S_HIT: begin
          if (count == last_count) state_next = S_IDLE;
        end
        default: state_next = state_reg;
      endcase
    end
    if (state_next != state_reg) enter = 1'b1;
  end

  always_comb begin
    phase_next = 5'd0;
    run_next   = 3'd0;
    if (state_next == S_RUN) begin
      if (enter) begin
        run_next = 3'd1;
      end else if (phase_reg == RUN_LAST) begin
        run_next = (run_state == 3'd4) ? 3'd1 : run_state + 3'd1;
      end else begin
        phase_next = phase_reg + 5'd1;
        run_next   = run_state;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset_h) begin
    if (Reset_h) begin
      state_reg  <= S_IDLE;
      phase_reg  <= 5'd0;
      in_air     <= 1'b0;
      move_right <= 1'b0;
      move_left  <= 1'b0;
      crouch     <= 1'b0;
      kick       <= 1'b0;
      punch      <= 1'b0;
      dir        <= 1'b0;
      p_hit      <= 1'b0;
      p_lose     <= 1'b0;
      run_state  <= 3'd0;
      count      <= 5'd0;
      boxsizex   <= BOX_NARROW;
    end else if (frame_tick) begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      run_state <= run_next;
      if (enter)               count <= 5'd0;
      else if (count != 5'd31) count <= count + 5'd1;

      if (state_reg == S_IDLE || state_reg == S_RUN || state_reg == S_CROUCH) begin
        if (go_right)     dir <= 1'b0;
        else if (go_left) dir <= 1'b1;
      end

      // Jump direction is captured at takeoff and held until landing.
      if (state_next == S_RUN || (state_next == S_JUMP && enter)) begin
        move_right <= go_right;
        move_left  <= go_left;
      end else if (state_next != S_JUMP) begin
        move_right <= 1'b0;
        move_left  <= 1'b0;
      end

      in_air <= (state_next == S_JUMP);
      crouch <= (state_next == S_CROUCH);
      kick   <= (state_next == S_KICK);
      punch  <= (state_next == S_PUNCH);
      p_hit  <= (state_next == S_HIT);
      p_lose <= (state_next == S_LOSE);
      boxsizex <= (state_next == S_KICK || state_next == S_PUNCH ||
                   (state_next == S_RUN && run_next >= 3'd3)) ? BOX_WIDE : BOX_NARROW;
    end
  end

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Directed plus randomized bench for fighter_anim_ctrl against a rule-level reference model.
module tb_fighter_anim_ctrl;
  logic CLK = 1'b0;
  logic Reset_h, frame_tick;
  logic key_left, key_right, key_up, key_down, key_kick, key_punch, hit_in, health_zero;
  logic in_air, move_right, move_left, crouch, kick, punch, dir, p_hit, p_lose;
  logic [2:0] run_state;
  logic [4:0] count;
  logic [9:0] boxsizex;

  fighter_anim_ctrl dut (
    .CLK(CLK), .Reset_h(Reset_h), .frame_tick(frame_tick),
    .key_left(key_left), .key_right(key_right), .key_up(key_up), .key_down(key_down),
    .key_kick(key_kick), .key_punch(key_punch), .hit_in(hit_in), .health_zero(health_zero),
    .in_air(in_air), .move_right(move_right), .move_left(move_left), .crouch(crouch),
    .kick(kick), .punch(punch), .dir(dir), .p_hit(p_hit), .p_lose(p_lose),
    .run_state(run_state), .count(count), .boxsizex(boxsizex)
  );

  always #5 CLK = ~CLK;

  localparam int M_IDLE = 0, M_RUN = 1, M_CROUCH = 2, M_JUMP = 3,
                 M_KICK = 4, M_PUNCH = 5, M_HIT = 6, M_LOSE = 7;
  localparam int STEP = 4;
  localparam logic [26:0] RESET_VEC = 27'd64;

  int m_state, m_count, m_run_ticks;
  logic m_dir, m_mr, m_ml;
`ifdef MK_HIT_INVULN_EN
  int m_inv;
`endif
  int n_checks = 0;
  int n_fail = 0;

  function automatic int dur(input int s);
    case (s)
      M_JUMP:  return 24;
      M_KICK:  return 12;
      M_PUNCH: return 8;
      M_HIT:   return 10;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [26:0] dut_vec();
    return {in_air, move_right, move_left, crouch, kick, punch, dir, p_hit, p_lose,
            run_state, count, boxsizex};
  endfunction

  function automatic logic [26:0] model_vec();
    logic [2:0] rs;
    logic [9:0] bx;
    rs = (m_state == M_RUN) ? 3'(1 + (m_run_ticks / STEP) % 4) : 3'd0;
    bx = (m_state == M_KICK || m_state == M_PUNCH || (m_state == M_RUN && rs >= 3'd3)) ? 10'd104 : 10'd64;
    return {m_state == M_JUMP, m_mr, m_ml, m_state == M_CROUCH, m_state == M_KICK,
            m_state == M_PUNCH, m_dir, m_state == M_HIT, m_state == M_LOSE, rs, 5'(m_count), bx};
  endfunction

  task automatic chk(input string tag, input logic [26:0] obs, input logic [26:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_count = 0; m_run_ticks = 0;
    m_dir = 1'b0; m_mr = 1'b0; m_ml = 1'b0;
`ifdef MK_HIT_INVULN_EN
    m_inv = 0;
`endif
  endtask

  task automatic model_step();
    int nxt;
    bit enter, gr, gl, free, hit_ok;
    gr = key_right && !key_left;
    gl = key_left && !key_right;
    free = (m_state == M_IDLE || m_state == M_RUN || m_state == M_CROUCH);
    hit_ok = hit_in && (m_state != M_LOSE);
`ifdef MK_HIT_INVULN_EN
    hit_ok = hit_ok && (m_inv == 0);
`endif
    nxt = m_state;
    enter = 0;
    if (health_zero) nxt = M_LOSE;
    else if (hit_ok) begin nxt = M_HIT; enter = 1; end
    else if (free) begin
      if (key_up)         nxt = M_JUMP;
      else if (key_down)  nxt = M_CROUCH;
      else if (key_kick)  nxt = M_KICK;
      else if (key_punch) nxt = M_PUNCH;
      else if (gr || gl)  nxt = M_RUN;
      else                nxt = M_IDLE;
    end else if (m_state != M_LOSE) begin
      if (m_count == dur(m_state) - 1) nxt = M_IDLE;
    end
    if (nxt != m_state) enter = 1;
`ifdef MK_HIT_INVULN_EN
    if (m_state == M_HIT && nxt == M_IDLE) m_inv = 16;
    else if (m_inv > 0) m_inv--;
`endif
    if (free) begin
      if (gr) m_dir = 1'b0;
      else if (gl) m_dir = 1'b1;
    end
    if (nxt == M_RUN || (nxt == M_JUMP && enter)) begin m_mr = gr; m_ml = gl; end
    else if (nxt != M_JUMP) begin m_mr = 1'b0; m_ml = 1'b0; end
    m_run_ticks = (nxt == M_RUN && !enter) ? m_run_ticks + 1 : 0;
    m_count = enter ? 0 : ((m_count < 31) ? m_count + 1 : 31);
    m_state = nxt;
  endtask

  task automatic set_in(input logic l, r, u, d, k, p, h, z);
    key_left = l; key_right = r; key_up = u; key_down = d;
    key_kick = k; key_punch = p; hit_in = h; health_zero = z;
  endtask

  task automatic do_tick(input string tag);
    @(negedge CLK);
    frame_tick = 1'b1;
    @(posedge CLK);
    #1;
    frame_tick = 1'b0;
    model_step();
    chk(tag, dut_vec(), model_vec());
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge CLK);
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(posedge CLK);
    #1;
    chk("no_tick_hold", dut_vec(), model_vec());
  endtask

  task automatic sync_reset_pulse();
    @(negedge CLK);
    Reset_h = 1'b1;
    @(negedge CLK);
    Reset_h = 1'b0;
    model_reset();
  endtask

  initial begin
    frame_tick = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    Reset_h = 1'b1;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_state", dut_vec(), RESET_VEC);
    @(negedge CLK);
    Reset_h = 1'b0;

    // Run right for 17 ticks through all phases
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 17; i++) begin
      do_tick("run_right");
      if (i == 9) chk("run_phase3_box", 27'(boxsizex), 27'd104);
      if (i == 17) chk("run_wrap_phase1", 27'(run_state), 27'd1);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    do_tick("release_idle");

    // Jump to the left, then release
    set_in(1, 0, 1, 0, 0, 0, 0, 0);
    do_tick("jump_entry");
    chk("jump_flags", {24'd0, in_air, move_left, dir}, 27'b111);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 24; i++) begin
      do_tick("jump_air");
      if (i == 23) chk("jump_still_air", 27'(in_air), 27'd1);
      if (i == 24) chk("jump_landed", {25'd0, in_air, move_left}, 27'd0);
    end

    // Kick with punch pressed during it
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    do_tick("kick_entry");
    chk("kick_box", {16'd0, kick, boxsizex}, {16'd0, 1'b1, 10'd104});
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      do_tick("kick_hold");
      if (i == 11) chk("kick_count11", 27'(count), 27'd11);
      if (i == 12) chk("kick_exit_no_punch", {25'd0, kick, punch}, 27'd0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    do_tick("idle2");

    // Punch interrupted by a hit at count 3
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    do_tick("punch_entry");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) do_tick("punch_hold");
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    do_tick("hit_entry");
    chk("hit_flags", {20'd0, p_hit, punch, count}, {20'd0, 1'b1, 1'b0, 5'd0});
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      do_tick("hit_stun");
      if (i == 10) chk("hit_exit", 27'(p_hit), 27'd0);
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) do_tick("hit_after_stun");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (12) do_tick("hit_recover");

    // Lose during a jump, then everything ignored
    set_in(0, 1, 1, 0, 0, 0, 0, 0);
    do_tick("jump2_entry");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (5) do_tick("jump2_air");
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    do_tick("lose_entry");
    chk("lose_flags", {25'd0, p_lose, in_air}, 27'b10);
    for (int i = 1; i <= 40; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0);
      do_tick("lose_hold");
    end
    chk("lose_count_sat", {21'd0, p_lose, count}, {21'd0, 1'b1, 5'd31});

    // Keys change with no frame tick
    gap(5);

    // Asynchronous reset mid-kick
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    sync_reset_pulse();
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    do_tick("kick2_entry");
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) do_tick("kick2_hold");
    #3;
    Reset_h = 1'b1;
    #1;
    chk("async_reset", dut_vec(), RESET_VEC);
    model_reset();
    @(negedge CLK);
    Reset_h = 1'b0;

    // Randomized play
    for (int i = 0; i < 800; i++) begin
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 19) == 0), ($urandom_range(0, 249) == 0));
      do_tick("random");
      if ($urandom_range(0, 9) == 0) gap($urandom_range(1, 3));
      if (m_state == M_LOSE && m_count >= 31) begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        sync_reset_pulse();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
